// File: rtl/dual_slope_sequencer.sv
// dual_slope_sequencer: dual-slope integrating ADC conversion controller with autoranging
module dual_slope_sequencer #(
  parameter int CNT_W     = 16,
  parameter int T_AZ      = 16,
  parameter int T_INT     = 1000,
  parameter int MAX_DEINT = 2000,
  parameter int REF_TO    = 255,
  parameter int RANGE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_sel_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [1:0]       afe_sel_o,
  output logic [2:0]       range_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             sign_o,
  output logic             result_valid_o,
  output logic             over_range_o,
  output logic             err_o,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_REF = 4'd1, AUTOZERO = 4'd2, INTEGRATE = 4'd3,
    SIGN = 4'd4, DEINT = 4'd5, DONE = 4'd6, ERROR = 4'd7
  } state_t;
  localparam logic [CNT_W-1:0] AZ_END    = CNT_W'(T_AZ - 1);
  localparam logic [CNT_W-1:0] INT_END   = CNT_W'(T_INT - 1);
  localparam logic [CNT_W-1:0] REF_END   = CNT_W'(REF_TO - 1);
  localparam logic [CNT_W-1:0] DEINT_MAX = CNT_W'(MAX_DEINT);
  localparam logic [CNT_W-1:0] LOW_RES   = CNT_W'(T_INT / 8);
  localparam logic [2:0]       R_MAX     = 3'(RANGE_MAX);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic sat, idle, go, hit;
  assign sat     = sat_hi_i | sat_lo_i;
  assign idle    = state == IDLE || state == ERROR;
  assign go      = idle && start_i && mode_sel_i != 2'b11;
  assign hit     = comp_i != ref_sign_o;
  assign state_o = state;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERROR: nxt = go ? WAIT_REF : state;
      WAIT_REF:    nxt = ref_ok_i ? AUTOZERO : cnt == REF_END ? ERROR : WAIT_REF;
      AUTOZERO:    nxt = cnt == AZ_END ? INTEGRATE : AUTOZERO;
      INTEGRATE:   nxt = sat ? (range_sel_o < R_MAX ? AUTOZERO : DONE) : cnt == INT_END ? SIGN : INTEGRATE;
      SIGN:        nxt = DEINT;
      DEINT:       nxt = (hit || cnt + 1'b1 == DEINT_MAX) ? DONE : DEINT;
      default:     nxt = IDLE;
    endcase
    if (abort_i && !idle) nxt = IDLE;
  end
  // cnt restarts on every state change, so it times whichever state is active
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      cnt            <= '0;
      afe_sel_o      <= 2'd0;
      range_sel_o    <= R_MAX;
      afe_reset_o    <= 1'b1;
      ref_sign_o     <= 1'b0;
      busy_o         <= 1'b0;
      result_o       <= '0;
      sign_o         <= 1'b0;
      result_valid_o <= 1'b0;
      over_range_o   <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state          <= nxt;
      cnt            <= nxt != state ? '0 : cnt + 1'b1;
      afe_reset_o    <= !(nxt inside {INTEGRATE, SIGN, DEINT});
      busy_o         <= !(nxt inside {IDLE, ERROR});
      result_valid_o <= nxt == DONE;
      err_o          <= nxt == ERROR || (err_o && !go);
      if (go) afe_sel_o <= mode_sel_i;
      if (state == SIGN && nxt == DEINT) begin
        sign_o     <= comp_i;
        ref_sign_o <= comp_i;
      end
      if (state == INTEGRATE && nxt == AUTOZERO) range_sel_o <= range_sel_o + 1'b1;
      if (state == DONE && !over_range_o && result_o < LOW_RES && |range_sel_o)
        range_sel_o <= range_sel_o - 1'b1;
      if (state == INTEGRATE && nxt == DONE) begin
        result_o     <= '1;
        over_range_o <= 1'b1;
      end
      if (state == DEINT && nxt == DONE) begin
        result_o     <= hit ? cnt : DEINT_MAX;
        over_range_o <= !hit;
      end
    end
  end
endmodule

// File: tb/tb_dual_slope_sequencer.sv
// tb_dual_slope_sequencer: scoreboard bench for the dual-slope conversion sequencer
module tb_dual_slope_sequencer;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, comp = 0, sat_hi = 0, sat_lo = 0, ref_ok = 0;
  logic [1:0] mode = 2'd0;
  logic [1:0] afe_sel_o;
  logic [2:0] range_sel_o;
  logic afe_reset_o, ref_sign_o, busy_o, sign_o, result_valid_o, over_range_o, err_o;
  logic [15:0] result_o;
  logic [3:0] state_o;
  typedef struct packed {logic [15:0] res; logic sgn; logic ovr;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  logic last_sign = 1'b0;
  logic [15:0] last_res = 16'd0;

  dual_slope_sequencer #(.CNT_W(16), .T_AZ(4), .T_INT(100), .MAX_DEINT(200), .REF_TO(50), .RANGE_MAX(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .mode_sel_i(mode),
    .comp_i(comp), .sat_hi_i(sat_hi), .sat_lo_i(sat_lo), .ref_ok_i(ref_ok),
    .afe_sel_o(afe_sel_o), .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o),
    .ref_sign_o(ref_sign_o), .busy_o(busy_o), .result_o(result_o), .sign_o(sign_o),
    .result_valid_o(result_valid_o), .over_range_o(over_range_o), .err_o(err_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && result_valid_o === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL strobe: unexpected result_valid_o with result_o=%0d, required no strobe", result_o);
      end else begin
        mon_e = sb.pop_front();
        if ({result_o, sign_o, over_range_o} !== mon_e) begin
          fails++;
          $display("FAIL result: got res=%0d sign=%b ovr=%b, required res=%0d sign=%b ovr=%b",
                   result_o, sign_o, over_range_o, mon_e.res, mon_e.sgn, mon_e.ovr);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [3:0] s, output int n);
    n = 0;
    while (state_o !== s && n < 500) begin tick(); n++; end
  endtask

  task automatic convert(input logic [1:0] m, input logic p, input int n, input bit hold);
    int lat, exp_lat;
    exp_t e;
    e = {(n >= 200) ? 16'd200 : 16'(n), p, n >= 200};
    sb.push_back(e);
    exp_lat = 108 + (n < 200 ? n : 199);
    comp = p; ref_ok = 1; mode = m; start = 1;
    tick(); lat = 1;
    if (hold) mode = m ^ 2'b01; else start = 0;
    while (state_o !== 4'd5 && lat < 400) begin tick(); lat++; end
    tests++;
    if (ref_sign_o !== p) begin
      fails++; $display("FAIL ref_sign: got %b, required %b", ref_sign_o, p);
    end
    for (int i = 0; i < n && result_valid_o !== 1'b1; i++) begin tick(); lat++; end
    start = 0; comp = ~p;
    while (result_valid_o !== 1'b1 && lat < 2000) begin tick(); lat++; end
    tests++;
    if (lat !== exp_lat) begin
      fails++; $display("FAIL latency: got %0d cycles, required %0d", lat, exp_lat);
    end
    tests++;
    if (afe_sel_o !== m) begin
      fails++; $display("FAIL afe_sel: got %0d, required %0d", afe_sel_o, m);
    end
    last_sign = p; last_res = e.res;
    tick();
    tests++;
    if (result_valid_o !== 1'b0) begin
      fails++; $display("FAIL strobe_width: valid still %b one cycle later, required 0", result_valid_o);
    end
  endtask

  task automatic check_reset_state(input string nm);
    logic [31:0] got, req;
    got = {state_o, afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o, busy_o, result_o, sign_o, result_valid_o, over_range_o, err_o};
    req = {4'd0, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++;
    if (got !== req) begin
      fails++; $display("FAIL %s: outputs got %h, required %h", nm, got, req);
    end
  endtask

  task automatic check_range(input string nm, input logic [2:0] r);
    tests++;
    if (range_sel_o !== r) begin
      fails++; $display("FAIL %s: range_sel_o got %0d, required %0d", nm, range_sel_o, r);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) tick();
    check_reset_state("reset");
    rst_n = 1;
    tick();
  endtask

  task automatic test_nominal;
    convert(2'd0, 1'b1, 57, 1'b0);
    check_range("nominal_range", 3'd4);
  endtask

  task automatic test_saturation;
    int n;
    sb.push_back({16'hFFFF, last_sign, 1'b1});
    comp = 1; ref_ok = 1; mode = 2'd0; start = 1;
    tick(); start = 0;
    wait_state(4'd3, n);
    repeat (29) tick();
    sat_lo = 1; tick(); sat_lo = 0;
    tests++;
    if ({state_o, range_sel_o, result_valid_o} !== {4'd6, 3'd4, 1'b1}) begin
      fails++; $display("FAIL sat_max: state=%0d range=%0d valid=%b, required 6/4/1", state_o, range_sel_o, result_valid_o);
    end
    last_res = 16'hFFFF;
    tick();
    convert(2'd1, 1'b1, 5, 1'b0);
    check_range("range_down_1", 3'd3);
    convert(2'd2, 1'b0, 5, 1'b1);
    check_range("range_down_2", 3'd2);
  endtask

  task automatic test_autorange_up;
    int n;
    comp = 1; ref_ok = 1; mode = 2'd0; start = 1;
    tick(); start = 0;
    wait_state(4'd3, n);
    repeat (29) tick();
    sat_hi = 1; tick(); sat_hi = 0;
    tests++;
    if ({state_o, range_sel_o} !== {4'd2, 3'd3}) begin
      fails++; $display("FAIL range_up: state=%0d range=%0d, required 2/3", state_o, range_sel_o);
    end
    n = 0;
    while (state_o === 4'd2 && n < 20) begin tick(); n++; end
    tests++;
    if (n !== 4) begin
      fails++; $display("FAIL az_len: got %0d cycles, required 4", n);
    end
    n = 0;
    while (state_o === 4'd3 && n < 200) begin tick(); n++; end
    tests++;
    if (n !== 100) begin
      fails++; $display("FAIL int_len: got %0d cycles, required 100", n);
    end
    sb.push_back({16'd10, 1'b1, 1'b0});
    wait_state(4'd5, n);
    repeat (10) tick();
    comp = 0;
    n = 0;
    while (result_valid_o !== 1'b1 && n < 50) begin tick(); n++; end
    last_sign = 1; last_res = 16'd10;
    tick();
    check_range("range_after_small", 3'd2);
  endtask

  task automatic test_ref_timeout;
    int n;
    ref_ok = 0; comp = 1; mode = 2'd0; start = 1;
    tick(); start = 0;
    n = 0;
    while (state_o !== 4'd7 && n < 100) begin tick(); n++; end
    tests++;
    if (n !== 50) begin
      fails++; $display("FAIL ref_to: ERROR after %0d cycles, required 50", n);
    end
    tests++;
    if ({err_o, busy_o, afe_reset_o} !== 3'b101) begin
      fails++; $display("FAIL err_state: err/busy/afe_reset got %b, required 101", {err_o, busy_o, afe_reset_o});
    end
    convert(2'd0, 1'b1, 30, 1'b0);
    tests++;
    if (err_o !== 1'b0) begin
      fails++; $display("FAIL err_clear: err_o got %b, required 0", err_o);
    end
    check_range("range_after_err", 3'd2);
  endtask

  task automatic test_deint_timeout;
    convert(2'd1, 1'b1, 1000, 1'b0);
    check_range("range_after_timeout", 3'd2);
  endtask

  task automatic test_reset_mid;
    int n;
    comp = 1; ref_ok = 1; mode = 2'd1; start = 1;
    tick(); start = 0;
    wait_state(4'd3, n);
    repeat (10) tick();
    rst_n = 0; tick();
    check_reset_state("reset_mid");
    rst_n = 1;
    last_sign = 0; last_res = 16'd0;
    tick();
  endtask

  task automatic test_abort;
    int n;
    comp = 1; ref_ok = 1; mode = 2'd0; start = 1;
    tick(); start = 0;
    wait_state(4'd5, n);
    repeat (5) tick();
    abort = 1; tick(); abort = 0;
    last_sign = 1;
    tests++;
    if ({state_o, busy_o, result_valid_o, result_o, sign_o} !== {4'd0, 1'b0, 1'b0, last_res, last_sign}) begin
      fails++; $display("FAIL abort: state=%0d busy=%b valid=%b res=%0d sign=%b, required 0/0/0/%0d/%b",
                        state_o, busy_o, result_valid_o, result_o, sign_o, last_res, last_sign);
    end
    repeat (5) tick();
  endtask

  task automatic test_mode11;
    mode = 2'd3; start = 1;
    repeat (3) tick();
    tests++;
    if ({state_o, busy_o, afe_sel_o} !== {4'd0, 1'b0, 2'd0}) begin
      fails++; $display("FAIL mode11: state=%0d busy=%b afe_sel=%0d, required 0/0/0", state_o, busy_o, afe_sel_o);
    end
    start = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_autorange_up();
    test_ref_timeout();
    test_deint_timeout();
    test_reset_mid();
    test_abort();
    test_mode11();
    tests++;
    if (sb.size() !== 0) begin
      fails++; $display("FAIL pending: %0d expected results never produced, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
